if_id_skid_reg: RTL and testbench

//   IF/ID pipeline register that takes the fetch address driven by the pc

---
 rtl/if_id_skid_reg.sv | 167 ++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID 2-entry skid register between fetch and decode.
// Optional IFID_PCPLUS4_EN adds a registered pc_plus4_out alongside pc_out.
module if_id_skid_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
`ifdef IFID_PCPLUS4_EN
    output logic [XLEN-1:0] pc_plus4_out,
`endif
    output logic [XLEN-1:0] instr_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Handshake outputs are kept as their own flops so neither side sees
    // a combinational decode of the state register.
    logic out_valid_q, out_valid_d;
    logic in_ready_q,  in_ready_d;

    logic [XLEN-1:0] main_pc_q,    main_pc_d;
    logic [XLEN-1:0] main_instr_q, main_instr_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;

`ifdef IFID_PCPLUS4_EN
    localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(4);

    logic [XLEN-1:0] main_pc4_q, main_pc4_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
    logic [XLEN-1:0] in_pc4;

    assign in_pc4 = pc_in + XLEN'(4);
`endif

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
`ifdef IFID_PCPLUS4_EN
        main_pc4_d   = main_pc4_q;
        skid_pc4_d   = skid_pc4_q;
`endif

        if (flush) begin
            // Redirect: drop held beats and the incoming one.
            state_d      = ST_EMPTY;
            main_pc_d    = RESET_PC;
            main_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = '0;
`ifdef IFID_PCPLUS4_EN
            main_pc4_d   = RESET_PC4;
            skid_pc4_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        main_pc_d    = pc_in;
                        main_instr_d = instr_in;
`ifdef IFID_PCPLUS4_EN
                        main_pc4_d   = in_pc4;
`endif
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_pc_d    = pc_in;
                        main_instr_d = instr_in;
`ifdef IFID_PCPLUS4_EN
                        main_pc4_d   = in_pc4;
`endif
                    end else if (accept) begin
                        state_d      = ST_FULL;
                        skid_pc_d    = pc_in;
                        skid_instr_d = instr_in;
`ifdef IFID_PCPLUS4_EN
                        skid_pc4_d   = in_pc4;
`endif
                    end else if (pop) begin
                        // main keeps the popped beat visible while empty
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d      = ST_ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
`ifdef IFID_PCPLUS4_EN
                        main_pc4_d   = skid_pc4_q;
`endif
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            main_pc_q    <= RESET_PC;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
`ifdef IFID_PCPLUS4_EN
            main_pc4_q   <= RESET_PC4;
            skid_pc4_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
`ifdef IFID_PCPLUS4_EN
            main_pc4_q   <= main_pc4_d;
            skid_pc4_q   <= skid_pc4_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign pc_out    = main_pc_q;
    assign instr_out = main_instr_q;
`ifdef IFID_PCPLUS4_EN
    assign pc_plus4_out = main_pc4_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - scoreboard bench for if_id_skid_reg.
// Beat queue model: FIFO of depth 2, flush/reset empty it, idle outputs hold last pop.
module tb_if_id_skid_reg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
`ifdef IFID_PCPLUS4_EN
    logic [31:0] pc_plus4_out;
`endif

    if_id_skid_reg #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pc_in    (pc_in),
        .instr_in (instr_in),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pc_out   (pc_out),
`ifdef IFID_PCPLUS4_EN
        .pc_plus4_out(pc_plus4_out),
`endif
        .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] last_pc    = RESET_PC;
    logic [31:0] last_instr = NOP_INSTR;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_pc    = RESET_PC;
        last_instr = NOP_INSTR;
    endtask

    // Stimulus side of the scoreboard: record every beat the DUT accepts.
    always @(posedge clk) begin
        if (reset && !flush && in_valid && in_ready)
            exp_q.push_back('{pc: pc_in, instr: instr_in});
    end

    // Monitor: pop and compare whenever decode takes a beat.
    always @(posedge clk) begin
        if (reset) begin
            if (flush) begin
                model_reset();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    chk("pop_pc", pc_out, exp_q[0].pc);
                    chk("pop_instr", instr_out, exp_q[0].instr);
                    last_pc    = exp_q[0].pc;
                    last_instr = exp_q[0].instr;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Status checks between edges: handshake flags and idle/held data.
    always @(negedge clk) begin
        if (reset) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            if (exp_q.size() != 0) begin
                chk("head_pc", pc_out, exp_q[0].pc);
                chk("head_instr", instr_out, exp_q[0].instr);
`ifdef IFID_PCPLUS4_EN
                chk("head_pc4", pc_plus4_out, exp_q[0].pc + 32'd4);
`endif
            end else begin
                chk("idle_pc", pc_out, last_pc);
                chk("idle_instr", instr_out, last_instr);
`ifdef IFID_PCPLUS4_EN
                chk("idle_pc4", pc_plus4_out, last_pc + 32'd4);
`endif
            end
        end
    end

    task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic ordy);
        in_valid  = iv;
        pc_in     = pc;
        instr_in  = ins;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pc", pc_out, RESET_PC);
        chk("rst_instr", instr_out, NOP_INSTR);
        reset = 1'b1;
        @(negedge clk);

        // single beat, next-cycle latency
        cyc(1'b1, 32'hAABB_CCDD, 32'h0010_0093, 1'b0, 1'b1);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_pc", pc_out, 32'hAABB_CCDD);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // fill to FULL, then drain in order
        cyc(1'b1, 32'h1234_5678, 32'h0000_1111, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234_567C, 32'h0000_2222, 1'b0, 1'b0);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_first_pc", pc_out, 32'h1234_5678);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t3_second_pc", pc_out, 32'h1234_567C);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t3_drained", 32'(out_valid), 32'd0);
        chk("t3_idle_holds", pc_out, 32'h1234_567C);

        // flush while FULL with a competing beat
        cyc(1'b1, 32'h0000_0100, 32'h0000_3333, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0104, 32'h0000_4444, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0040, 32'h0000_5555, 1'b1, 1'b1);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_ready", 32'(in_ready), 32'd1);
        chk("t4_pc", pc_out, RESET_PC);
        chk("t4_instr", instr_out, NOP_INSTR);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t4_no_0x40", 32'(pc_out == 32'h0000_0040), 32'd0);

        // asynchronous reset while FULL
        cyc(1'b1, 32'h0000_0200, 32'h0000_6666, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0204, 32'h0000_7777, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        chk("t5_pc", pc_out, RESET_PC);
        chk("t5_instr", instr_out, NOP_INSTR);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 32'h0000_0300, 32'h0000_8888, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("t5_first_pc", pc_out, 32'h0000_0300);

        // top-of-address-space pc passes through unmodified
        cyc(1'b1, 32'hFFFF_FFFC, 32'h0000_9999, 1'b0, 1'b1);
        chk("t6_pc", pc_out, 32'hFFFF_FFFC);
`ifdef IFID_PCPLUS4_EN
        chk("t6_pc4", pc_plus4_out, 32'h0000_0000);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            cyc(1'($urandom_range(0, 1)), rpc, $urandom,
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 7));
        end

        for (int i = 0; i < 4; i++)
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
